input_vc_arbiter: RTL and testbench



---
 rtl/exanet_vc_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/input_vc_arbiter.sv | 143 ++++++++++++++
 tb/tb_input_vc_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exanet_vc_pkg.sv
// Shared state type and sizing helpers for the per-input VC arbiter.
package exanet_vc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, GRANTED} arb_state_t;

    function automatic int unsigned calc_vcs(int unsigned vc_num, int unsigned prio_num);
        return vc_num * prio_num;
    endfunction

    function automatic int unsigned calc_vcw(int unsigned vcs);
        return (vcs > 1) ? $clog2(vcs) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest request at or above the pointer wins, else lowest overall.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] sel;
    logic         found;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        // Fall back to the unmasked vector when nothing sits at or above the pointer.
        sel = (|masked) ? masked : req;
        gnt = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel[i] && !found) begin
                gnt[i] = 1'b1;
                idx = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_vc_arbiter.sv
// Packet-granular input VC arbiter; INPUT_ARB_STRICT_PRIO_EN selects strict priority
// between classes, otherwise flat round-robin over all VCs.
module input_vc_arbiter
    import exanet_vc_pkg::*;
#(
    parameter int unsigned vc_num = 3,
    parameter int unsigned prio_num = 2,
    parameter int unsigned output_num = 8,
    localparam int unsigned VCS = calc_vcs(vc_num, prio_num),
    localparam int unsigned VCW = calc_vcw(VCS)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [VCS-1:0]                   i_has_packet,
    input  logic [VCS-1:0][output_num-1:0]   i_dest,
    input  logic [VCS-1:0][VCW-1:0]          i_output_vc,
    input  logic                             cts,
    input  logic                             last,
    output logic [output_num-1:0]            o_req,
    output logic [VCW-1:0]                   o_selected_vc,
    output logic [VCW-1:0]                   o_output_vc,
    output logic                             o_granted
);

    arb_state_t     state_q;
    logic [VCS-1:0] eligible;
    logic           win_valid;
    logic [VCW-1:0] win_idx;

    always_comb begin
        for (int i = 0; i < VCS; i++) begin
            eligible[i] = i_has_packet[i] & (|i_dest[i]);
        end
    end

`ifdef INPUT_ARB_STRICT_PRIO_EN
    localparam int unsigned CW = (vc_num > 1) ? $clog2(vc_num) : 1;

    logic [prio_num-1:0][CW-1:0]     cls_ptr_q;
    logic [prio_num-1:0][CW-1:0]     cls_idx;
    logic [prio_num-1:0][vc_num-1:0] cls_gnt;
    int unsigned                     sel_cls;
    int unsigned                     sel_loc;

    for (genvar p = 0; p < prio_num; p++) begin : g_cls
        rr_arbiter #(
            .N (vc_num)
        ) u_rr (
            .req (eligible[p*vc_num +: vc_num]),
            .ptr (cls_ptr_q[p]),
            .gnt (cls_gnt[p]),
            .idx (cls_idx[p])
        );
    end

    // Higher class index overrides lower, so the last valid class in the loop wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx = '0;
        for (int p = 0; p < prio_num; p++) begin
            if (|cls_gnt[p]) begin
                win_valid = 1'b1;
                win_idx = VCW'(p * vc_num) + VCW'(cls_idx[p]);
            end
        end
        sel_cls = 32'(o_selected_vc) / vc_num;
        sel_loc = 32'(o_selected_vc) % vc_num;
    end
`else
    logic [VCS-1:0] gnt;
    logic [VCW-1:0] ptr_q;

    rr_arbiter #(
        .N (VCS)
    ) u_rr (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign win_valid = |gnt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            o_req         <= '0;
            o_selected_vc <= '0;
            o_output_vc   <= '0;
            o_granted     <= 1'b0;
`ifdef INPUT_ARB_STRICT_PRIO_EN
            cls_ptr_q     <= '0;
`else
            ptr_q         <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q       <= REQ;
                        o_req         <= i_dest[win_idx];
                        o_selected_vc <= win_idx;
                        o_output_vc   <= i_output_vc[win_idx];
                    end
                end
                REQ: begin
                    // A last arriving with cts belongs to no granted packet and is dropped.
                    if (cts) begin
                        state_q   <= GRANTED;
                        o_granted <= 1'b1;
                    end else if (!i_has_packet[o_selected_vc]) begin
                        state_q       <= IDLE;
                        o_req         <= '0;
                        o_selected_vc <= '0;
                        o_output_vc   <= '0;
                    end
                end
                GRANTED: begin
                    if (last) begin
                        state_q       <= IDLE;
                        o_req         <= '0;
                        o_selected_vc <= '0;
                        o_output_vc   <= '0;
                        o_granted     <= 1'b0;
`ifdef INPUT_ARB_STRICT_PRIO_EN
                        for (int unsigned p = 0; p < prio_num; p++) begin
                            if (sel_cls == p) begin
                                cls_ptr_q[p] <= (sel_loc == vc_num - 1) ? '0 : CW'(sel_loc + 1);
                            end
                        end
`else
                        ptr_q <= (o_selected_vc == VCW'(VCS - 1)) ? '0
                                                                  : o_selected_vc + VCW'(1);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_vc_arbiter.sv
// Self-checking bench for input_vc_arbiter: directed scenarios plus random traffic vs a model.
module tb_input_vc_arbiter;

    localparam int VC = 3;
    localparam int PRIO = 2;
    localparam int VCS = VC * PRIO;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [5:0]     has = '0;
    logic [5:0][7:0] dest = '0;
    logic [5:0][2:0] ovc = '0;
    logic           cts = 1'b0;
    logic           last = 1'b0;
    logic [7:0]     o_req;
    logic [2:0]     o_selected_vc;
    logic [2:0]     o_output_vc;
    logic           o_granted;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 = no packet, 1 = requesting, 2 = transferring.
    int         m_phase;
    int         m_sel;
    logic [7:0] m_req;
    int         m_ovc;
    int         m_ptr;
    int         m_cls_ptr[PRIO];

    always #5 clk = ~clk;

    input_vc_arbiter dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_has_packet  (has),
        .i_dest        (dest),
        .i_output_vc   (ovc),
        .cts           (cts),
        .last          (last),
        .o_req         (o_req),
        .o_selected_vc (o_selected_vc),
        .o_output_vc   (o_output_vc),
        .o_granted     (o_granted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit elig(int v);
        return has[v] && (dest[v] != 8'h00);
    endfunction

    function automatic int pick();
`ifdef INPUT_ARB_STRICT_PRIO_EN
        for (int p = PRIO - 1; p >= 0; p--) begin
            for (int k = 0; k < VC; k++) begin
                int v;
                v = p * VC + (m_cls_ptr[p] + k) % VC;
                if (elig(v)) return v;
            end
        end
`else
        for (int k = 0; k < VCS; k++) begin
            int v;
            v = (m_ptr + k) % VCS;
            if (elig(v)) return v;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_sel = 0;
        m_req = '0;
        m_ovc = 0;
        m_ptr = 0;
        for (int p = 0; p < PRIO; p++) m_cls_ptr[p] = 0;
    endtask

    task automatic model_update();
        int w;
        case (m_phase)
            0: begin
                w = pick();
                if (w >= 0) begin
                    m_phase = 1;
                    m_sel = w;
                    m_req = dest[w];
                    m_ovc = int'(ovc[w]);
                end
            end
            1: begin
                if (cts) m_phase = 2;
                else if (!has[m_sel]) m_phase = 0;
            end
            default: begin
                if (last) begin
                    m_phase = 0;
                    m_ptr = (m_sel + 1) % VCS;
                    m_cls_ptr[m_sel / VC] = (m_sel % VC + 1) % VC;
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, "_req"}, o_req, (m_phase != 0) ? m_req : 8'h00);
        check({tag, "_sel"}, o_selected_vc, (m_phase != 0) ? m_sel : 0);
        check({tag, "_ovc"}, o_output_vc, (m_phase != 0) ? m_ovc : 0);
        check({tag, "_gnt"}, o_granted, (m_phase == 2) ? 1 : 0);
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_model("reset");
        resetn = 1'b1;
    endtask

    // One full packet from IDLE: request, cts, last; checks the winning VC.
    task automatic do_packet(input string tag, input int exp_vc);
        cts = 1'b0;
        last = 1'b0;
        step(tag);
        check({tag, "_order"}, o_selected_vc, exp_vc);
        cts = 1'b1;
        step(tag);
        cts = 1'b0;
        last = 1'b1;
        step(tag);
        last = 1'b0;
    endtask

    int order_all[7];
    int order_two[4];
    int abort_win;

    initial begin
`ifdef INPUT_ARB_STRICT_PRIO_EN
        order_all = '{3, 4, 5, 3, 4, 5, 3};
        order_two = '{4, 4, 4, 1};
        abort_win = 5;
`else
        order_all = '{0, 1, 2, 3, 4, 5, 0};
        order_two = '{1, 4, 1, 1};
        abort_win = 2;
`endif
        model_reset();
        #2;
        check_model("por");
        do_reset();

        // Single packet on VC2.
        has = 6'b000100;
        dest[2] = 8'h10;
        ovc[2] = 3'd2;
        step("t1_idle");
        check("t1_req", o_req, 8'h10);
        check("t1_sel", o_selected_vc, 2);
        cts = 1'b1;
        step("t1_cts");
        check("t1_gnt", o_granted, 1);
        cts = 1'b0;
        last = 1'b1;
        step("t1_last");
        check("t1_done", o_req, 8'h00);
        last = 1'b0;
        has = '0;
        step("t1_quiet");

        // All VCs pending.
        do_reset();
        for (int i = 0; i < VCS; i++) begin
            dest[i] = 8'h01 << i;
            ovc[i] = 3'(VCS - 1 - i);
        end
        has = 6'b111111;
        for (int i = 0; i < 7; i++) do_packet("t2", order_all[i]);
        has = '0;
        step("t2_quiet");

        // VCs 1 and 4 pending; VC4 drops after three packets.
        do_reset();
        has = 6'b010010;
        for (int i = 0; i < 3; i++) do_packet("t3", order_two[i]);
        has = 6'b000010;
        do_packet("t3", order_two[3]);
        has = '0;
        step("t3_quiet");

        // Abort in REQ leaves the pointer alone.
        do_reset();
        has = 6'b000100;
        step("t4_req");
        has = '0;
        step("t4_abort");
        check("t4_idle_req", o_req, 8'h00);
        has = 6'b100100;
        step("t4_rearb");
        check("t4_same", o_selected_vc, abort_win);
        has = '0;
        step("t4_drop");

        // cts and last together in REQ.
        has = 6'b000001;
        step("t5_req");
        cts = 1'b1;
        last = 1'b1;
        step("t5_both");
        cts = 1'b0;
        last = 1'b0;
        step("t5_hold");
        step("t5_hold");
        check("t5_still", o_granted, 1);
        last = 1'b1;
        step("t5_last");
        last = 1'b0;
        has = '0;

        // Asynchronous reset while granted.
        has = 6'b001000;
        step("t6_req");
        cts = 1'b1;
        step("t6_gnt");
        cts = 1'b0;
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("t6_async_gnt", o_granted, 0);
        check("t6_async_req", o_req, 8'h00);
        check("t6_async_sel", o_selected_vc, 0);
        #3;
        has = '0;
        resetn = 1'b1;
        step("t6_post");

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) has = 6'($urandom);
            for (int i = 0; i < VCS; i++) begin
                dest[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h01 << $urandom_range(0, 7);
                ovc[i] = 3'($urandom_range(0, VCS - 1));
            end
            cts = ($urandom_range(0, 2) == 0);
            last = ($urandom_range(0, 2) == 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
